display_scan_mux: RTL and testbench

Time-multiplexed driver for a common-anode 7-segment display bank. It consumes the slow square wave produced by the clock divider stage and advances one digit per rising edge of that wave. For the selected digit it drives the anode line, the decoded hex glyph and the decimal point. All logic runs in the single `clk_in` domain; the divider output is treated as an asynchronous input.

---
 rtl/display_scan_mux_if.sv | 22 ++
 rtl/display_scan_mux.sv | 117 +++++++++++
 tb/tb_display_scan_mux.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/display_scan_mux_if.sv
// Display scan bus: the refresh wave, digit data and decimal-point requests in,
// and the active-low anode/cathode drive out.
interface display_scan_mux_if #(
    parameter int N_DIGITS = 8
);
    logic                    refresh_clk;
    logic [4*N_DIGITS-1:0]   value;
    logic [N_DIGITS-1:0]     dp_mask;
    logic [N_DIGITS-1:0]     anodes;
    logic [6:0]              segments;
    logic                    dp;

    modport master (
        output refresh_clk, value, dp_mask,
        input  anodes, segments, dp
    );

    modport slave (
        input  refresh_clk, value, dp_mask,
        output anodes, segments, dp
    );
endinterface

// File: rtl/display_scan_mux.sv
// Common-anode 7-segment scan driver: one digit per rising edge of refresh_clk.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 never blanked).
module display_scan_mux #(
    parameter int N_DIGITS = 8
) (
    input  logic               clk_in,
    input  logic               reset,
    display_scan_mux_if.slave  bus
);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic                 sync0_q, sync0_d;
    logic                 sync1_q, sync1_d;
    logic                 prev_q, prev_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [N_DIGITS-1:0]  anodes_q, anodes_d;
    logic [6:0]           segments_q, segments_d;
    logic                 dp_q, dp_d;

    logic                 adv;
    logic [3:0]           nibble;
    logic                 dp_sel;
    logic                 blank;
`ifdef LEADING_ZERO_BLANK_EN
    logic [N_DIGITS-1:0]  blank_vec;
    logic                 zero_run;
`endif

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    always_comb begin
        sync0_d = bus.refresh_clk;
        sync1_d = sync0_q;
        prev_d  = sync1_q;
        adv     = sync1_q & ~prev_q;

        idx_d = idx_q;
        if (adv) begin
            if (idx_q == IDX_W'(N_DIGITS - 1)) idx_d = '0;
            else                               idx_d = idx_q + IDX_W'(1);
        end

        // A digit is blank when it and every higher nibble are zero.
`ifdef LEADING_ZERO_BLANK_EN
        zero_run  = 1'b1;
        blank_vec = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run & (bus.value[4*i +: 4] == 4'h0);
            blank_vec[i] = (i > 0) && zero_run;
        end
`endif

        nibble   = 4'h0;
        dp_sel   = 1'b0;
        blank    = 1'b0;
        anodes_d = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nibble      = bus.value[4*i +: 4];
                dp_sel      = bus.dp_mask[i];
                anodes_d[i] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
                blank       = blank_vec[i];
`endif
            end
        end

        segments_d = blank ? 7'b1111111 : glyph(nibble);
        dp_d       = ~dp_sel;
    end

    // Reset darkens the display and drops any refresh edge in flight.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync0_q    <= 1'b0;
            sync1_q    <= 1'b0;
            prev_q     <= 1'b0;
            idx_q      <= '0;
            anodes_q   <= '1;
            segments_q <= 7'b1111111;
            dp_q       <= 1'b1;
        end else begin
            sync0_q    <= sync0_d;
            sync1_q    <= sync1_d;
            prev_q     <= prev_d;
            idx_q      <= idx_d;
            anodes_q   <= anodes_d;
            segments_q <= segments_d;
            dp_q       <= dp_d;
        end
    end

    assign bus.anodes   = anodes_q;
    assign bus.segments = segments_q;
    assign bus.dp       = dp_q;
endmodule

// File: tb/tb_display_scan_mux.sv
// Directed-vector bench for display_scan_mux (8 digits), expectations hand-derived.
module tb_display_scan_mux;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LEAD_ZERO = 7'b1111111;
`else
    localparam logic [6:0] LEAD_ZERO = 7'b1000000;
`endif

    display_scan_mux_if #(.N_DIGITS(8)) bus ();

    display_scan_mux #(.N_DIGITS(8)) dut (
        .clk_in (clk),
        .reset  (reset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Rising edge held 2 cycles, low 2 cycles: outputs show the new digit on return.
    task automatic pulse();
        bus.refresh_clk = 1'b1;
        tick();
        tick();
        bus.refresh_clk = 1'b0;
        tick();
        tick();
    endtask

    task automatic check_digit(input string tag, input int k, input logic [6:0] seg);
        logic [7:0] an;
        an    = 8'hFF;
        an[k] = 1'b0;
        check_val({tag, "_an"}, 32'(bus.anodes), 32'(an));
        check_val({tag, "_seg"}, 32'(bus.segments), 32'(seg));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset           = 1'b1;
        bus.refresh_clk = 1'b0;
        bus.value       = 32'h0123_4567;
        bus.dp_mask     = 8'h00;

        // Reset with refresh toggling: stays dark, no advance.
        for (int i = 0; i < 3; i++) begin
            bus.refresh_clk = (i == 1);
            tick();
            check_val("rst_an", 32'(bus.anodes), 32'hFF);
            check_val("rst_seg", 32'(bus.segments), 32'h7F);
            check_val("rst_dp", 32'(bus.dp), 32'h1);
        end
        reset = 1'b0;
        tick();
        check_digit("rel", 0, 7'b1111000);
        check_val("rel_dp", 32'(bus.dp), 32'h1);
        tick();
        tick();
        tick();
        check_digit("rel_hold", 0, 7'b1111000);

        // Full scan of 0123_4567, wrapping back to digit 0.
        for (int k = 1; k <= 8; k++) begin
            pulse();
            check_digit($sformatf("scan%0d", k % 8), k % 8, GLYPH[7 - (k % 8)]);
        end

        // Latency: change lands on the 4th edge; a held-high level adds nothing.
        bus.refresh_clk = 1'b1;
        tick();
        tick();
        tick();
        check_val("lat3_an", 32'(bus.anodes), 32'hFE);
        tick();
        check_val("lat4_an", 32'(bus.anodes), 32'hFD);
        for (int i = 0; i < 10; i++) tick();
        check_val("lat_hold_an", 32'(bus.anodes), 32'hFD);
        bus.refresh_clk = 1'b0;
        tick();
        tick();

        // Reset mid-scan at digit 5.
        for (int i = 0; i < 4; i++) pulse();
        check_val("mid_an5", 32'(bus.anodes), 32'hDF);
        reset = 1'b1;
        tick();
        check_val("mid_rst_an", 32'(bus.anodes), 32'hFF);
        check_val("mid_rst_seg", 32'(bus.segments), 32'h7F);
        reset = 1'b0;
        tick();
        check_val("mid_rel_an", 32'(bus.anodes), 32'hFE);

        // Hex glyphs and decimal points.
        bus.value   = 32'hFEDC_BA98;
        bus.dp_mask = 8'h81;
        tick();
        check_digit("hex0", 0, 7'b0000000);
        check_val("hex0_dp", 32'(bus.dp), 32'h0);
        pulse();
        check_digit("hex1", 1, 7'b0010000);
        check_val("hex1_dp", 32'(bus.dp), 32'h1);
        for (int i = 0; i < 6; i++) pulse();
        check_digit("hex7", 7, 7'b0001110);
        check_val("hex7_dp", 32'(bus.dp), 32'h0);
        bus.value = 32'h5EDC_BA98;
        tick();
        check_val("live_seg", 32'(bus.segments), 32'(7'b0010010));

        // Leading zeros.
        bus.value   = 32'h0000_0042;
        bus.dp_mask = 8'h04;
        pulse();
        check_digit("lz0", 0, 7'b0100100);
        pulse();
        check_digit("lz1", 1, 7'b0011001);
        pulse();
        check_digit("lz2", 2, LEAD_ZERO);
        check_val("lz2_dp", 32'(bus.dp), 32'h0);
        bus.value = 32'h0;
        tick();
        check_digit("zero2", 2, LEAD_ZERO);
        for (int k = 3; k <= 8; k++) begin
            pulse();
            check_digit($sformatf("zero%0d", k % 8), k % 8,
                        (k == 8) ? 7'b1000000 : LEAD_ZERO);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
